// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative RV32M multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, with sign fix-up at the end.
module alu_muldiv_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         flush,
    output logic         busy,
    output logic         stall,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t         r_state;
    logic [2:0]     r_op;
    logic [N-1:0]   r_a, r_b, r_d, r_result;
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_neg_q, r_neg_r, r_done;

    logic           w_div, w_sa, w_sb, w_na, w_nb, w_dz, w_ovf, w_geq;
    logic [N-1:0]   w_ma, w_mb, w_spec, w_diff, w_quo, w_rem, w_fix;
    logic [N:0]     w_sum, w_rsh;
    logic [2*N-1:0] w_prod;

    assign w_div  = r_op[2];
    assign w_sa   = (r_op == 3'b001) | (r_op == 3'b010) | (r_op == 3'b100) | (r_op == 3'b110);
    assign w_sb   = (r_op == 3'b001) | (r_op == 3'b100) | (r_op == 3'b110);
    assign w_na   = w_sa & r_a[N-1];
    assign w_nb   = w_sb & r_b[N-1];
    assign w_ma   = w_na ? -r_a : r_a;
    assign w_mb   = w_nb ? -r_b : r_b;
    assign w_dz   = w_div & (r_b == '0);
    assign w_ovf  = w_div & ~r_op[0] & (r_a == {1'b1, {(N-1){1'b0}}}) & (r_b == '1);
    // op[1] separates remainder ops from quotient ops within the divide group
    assign w_spec = w_dz ? (r_op[1] ? r_a : '1) : (r_op[1] ? '0 : r_a);

    assign w_sum  = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_d} : '0);
    assign w_rsh  = r_acc[2*N-1:N-1];
    assign w_geq  = w_rsh >= {1'b0, r_d};
    assign w_diff = w_rsh[N-1:0] - r_d;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[N-1:0] : r_acc[N-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*N-1:N] : r_acc[2*N-1:N];
    assign w_fix  = w_div ? (r_op[1] ? w_rem : w_quo)
                          : ((r_op[1:0] == 2'b00) ? w_prod[N-1:0] : w_prod[2*N-1:N]);

    assign busy   = (r_state == PREP) | (r_state == RUN) | (r_state == FIX);
    assign stall  = busy | ((r_state == IDLE) & start & ~flush);
    assign done   = r_done;
    assign result = r_result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start && !flush) begin
                    r_op    <= op;
                    r_a     <= a;
                    r_b     <= b;
                    r_state <= PREP;
                end
                PREP: begin
                    r_acc   <= {{N{1'b0}}, w_ma};
                    r_d     <= w_mb;
                    r_cnt   <= CW'(N);
                    r_neg_q <= w_na ^ w_nb;
                    r_neg_r <= w_na;
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (w_dz || w_ovf) begin
                        r_result <= w_spec;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: if (flush) begin
                    r_state <= IDLE;
                end else begin
                    r_acc   <= w_div ? (w_geq ? {w_diff, r_acc[N-2:0], 1'b1} : {r_acc[2*N-2:0], 1'b0})
                                     : {w_sum, r_acc[N-1:1]};
                    r_cnt   <= r_cnt - CW'(1);
                    r_state <= (r_cnt == CW'(1)) ? FIX : RUN;
                end
                FIX: if (flush) begin
                    r_state <= IDLE;
                end else begin
                    r_result <= w_fix;
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
